// File: rtl/ps2_keystate_receiver.sv
// PS/2 keyboard receiver with key-state tracking.
// Synchronizes the keyboard clock/data pins, deframes 11-bit PS/2 frames
// (start, 8 data LSB first, odd parity, stop), and maintains a 128-bit
// key-down bitmap driven by make / F0-break / E0-extended scan code bytes.
module ps2_keystate_receiver #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        PS2_KBCLK,
  input  logic        PS2_KBDAT,
  output logic [63:0] REG0,
  output logic [63:0] REG1,
  output logic [7:0]  SCAN_CODE,
  output logic        SCAN_VALID,
  output logic        FRAME_ERR
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]    r_clkSync;
  logic [1:0]    r_datSync;
  logic          r_clkPrev;
  logic [1:0]    r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitCnt;
  logic          r_parityOk;
  logic [TW-1:0] r_toCnt;
  logic [7:0]    r_scanCode;
  logic          r_scanValid;
  logic          r_frameErr;
  logic          r_breakFlag;
  logic          r_extFlag;
  logic [127:0]  r_keys;

  logic w_fall;
  logic w_dat;
  logic w_timeout;
  logic w_isBreak;
  logic w_isExt;

  // A falling keyboard clock is the only moment the data line is looked at.
  assign w_fall    = r_clkPrev & ~r_clkSync[1];
  assign w_dat     = r_datSync[1];
  assign w_timeout = (r_state != S_IDLE) && (r_toCnt == TIMEOUT_MAX);
  assign w_isBreak = (r_scanCode == 8'hF0);
  assign w_isExt   = (r_scanCode == 8'hE0);

  assign REG0       = r_keys[63:0];
  assign REG1       = r_keys[127:64];
  assign SCAN_CODE  = r_scanCode;
  assign SCAN_VALID = r_scanValid;
  assign FRAME_ERR  = r_frameErr;

  // Two-stage synchronizers on both pins plus an edge register on the clock; idle bus reads as 1.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_clkSync <= 2'b11;
      r_datSync <= 2'b11;
      r_clkPrev <= 1'b1;
    end else begin
      r_clkSync <= {r_clkSync[0], PS2_KBCLK};
      r_datSync <= {r_datSync[0], PS2_KBDAT};
      r_clkPrev <= r_clkSync[1];
    end
  end

  // Mid-frame idle timer: cleared by each keyboard clock edge, saturates at the limit.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_toCnt <= '0;
    end else if (w_fall) begin
      r_toCnt <= '0;
    end else if ((r_state != S_IDLE) && (r_toCnt != TIMEOUT_MAX)) begin
      r_toCnt <= r_toCnt + TW'(1);
    end
  end

  // Frame state machine: deframes bits, checks odd parity and stop, emits byte or error pulse.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_shift     <= 8'h00;
      r_bitCnt    <= 3'd0;
      r_parityOk  <= 1'b0;
      r_scanCode  <= 8'h00;
      r_scanValid <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_scanValid <= 1'b0;
      r_frameErr  <= 1'b0;
      if (w_timeout) begin
        r_state    <= S_IDLE;
        r_shift    <= 8'h00;
        r_bitCnt   <= 3'd0;
        r_frameErr <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          S_IDLE: begin
            if (!w_dat) begin
              r_state  <= S_DATA;
              r_bitCnt <= 3'd0;
            end
          end
          S_DATA: begin
            r_shift  <= {w_dat, r_shift[7:1]};
            r_bitCnt <= r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) begin
              r_state <= S_PARITY;
            end
          end
          S_PARITY: begin
            r_parityOk <= ^{w_dat, r_shift};
            r_state    <= S_STOP;
          end
          S_STOP: begin
            if (w_dat && r_parityOk) begin
              r_scanCode  <= r_shift;
              r_scanValid <= 1'b1;
            end else begin
              r_frameErr <= 1'b1;
            end
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Scan code decoder: prefixes accumulate in flags, plain codes update the bitmap and clear them.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_keys      <= '0;
      r_breakFlag <= 1'b0;
      r_extFlag   <= 1'b0;
    end else if (r_frameErr) begin
      r_breakFlag <= 1'b0;
      r_extFlag   <= 1'b0;
    end else if (r_scanValid) begin
      if (w_isBreak || w_isExt) begin
        r_breakFlag <= r_breakFlag | w_isBreak;
        r_extFlag   <= r_extFlag | w_isExt;
      end else begin
        if (!r_scanCode[7]) begin
          r_keys[r_scanCode[6:0]] <= ~r_breakFlag;
        end
        r_breakFlag <= 1'b0;
        r_extFlag   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keystate_receiver.sv
// Directed bench for ps2_keystate_receiver: drives PS/2 frames bit by bit
// and compares outputs and decoder flags against hand-computed values.
module tb_ps2_keystate_receiver;

  localparam int TIMEOUT = 200;
  localparam int HALF    = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        kbClk;
  logic        kbDat;
  logic [63:0] reg0;
  logic [63:0] reg1;
  logic [7:0]  scanCode;
  logic        scanValid;
  logic        frameErr;

  int checksDone   = 0;
  int checksPassed = 0;
  int cyc          = 0;
  int validCount   = 0;
  int errCount     = 0;
  int validCyc     = 0;
  int stopCyc      = 0;
  int v0;
  int e0;
  int fc;
  logic [10:0] frame;

  ps2_keystate_receiver #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLOCK_50  (clk),
    .RESET     (rst),
    .PS2_KBCLK (kbClk),
    .PS2_KBDAT (kbDat),
    .REG0      (reg0),
    .REG1      (reg1),
    .SCAN_CODE (scanCode),
    .SCAN_VALID(scanValid),
    .FRAME_ERR (frameErr)
  );

  // 50 MHz board clock.
  always #10 clk = ~clk;

  // Free-running cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (scanValid) begin
      validCount <= validCount + 1;
      validCyc   <= cyc;
    end
    if (frameErr) errCount <= errCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checksDone = checksDone + 1;
    if (obs === exp) checksPassed = checksPassed + 1;
    else $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [10:0] makeFrame(input logic [7:0] code, input bit badParity);
    logic p;
    p = ~(^code) ^ badParity;
    return {1'b1, p, code, 1'b0};
  endfunction

  task automatic sendBit(input logic b, output int fallCyc);
    kbDat = b;
    repeat (HALF) @(negedge clk);
    kbClk   = 1'b0;
    fallCyc = cyc;
    repeat (HALF) @(negedge clk);
    kbClk = 1'b1;
  endtask

  task automatic sendBits(input logic [10:0] f, input int first, input int last);
    int fcLocal;
    for (int i = first; i <= last; i++) begin
      sendBit(f[i], fcLocal);
      if (i == 10) stopCyc = fcLocal;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] code, input bit badParity);
    sendBits(makeFrame(code, badParity), 0, 10);
    repeat (30) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    kbClk = 1'b1;
    kbDat = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_reg0", reg0, 64'h0);
    checkOutput("rst_reg1", reg1, 64'h0);
    checkOutput("rst_code", {56'h0, scanCode}, 64'h0);
    checkOutput("rst_pulses", {62'h0, scanValid, frameErr}, 64'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single make of 0x1C.
    v0 = validCount;
    applyStimulus(8'h1C, 1'b0);
    checkOutput("make1c_valid", 64'(validCount - v0), 64'd1);
    checkOutput("make1c_latency", 64'(validCyc - stopCyc), 64'd3);
    checkOutput("make1c_code", {56'h0, scanCode}, 64'h1C);
    checkOutput("make1c_reg0", reg0, 64'h1 << 28);
    checkOutput("make1c_reg1", reg1, 64'h0);

    // Break of 0x1C.
    applyStimulus(8'hF0, 1'b0);
    checkOutput("f0_break_flag", {63'h0, dut.r_breakFlag}, 64'h1);
    checkOutput("f0_reg0_hold", reg0, 64'h1 << 28);
    applyStimulus(8'h1C, 1'b0);
    checkOutput("break1c_reg0", reg0, 64'h0);
    checkOutput("break1c_flag", {63'h0, dut.r_breakFlag}, 64'h0);

    // Extended make aliases onto the plain code bit.
    applyStimulus(8'hE0, 1'b0);
    checkOutput("e0_ext_flag", {63'h0, dut.r_extFlag}, 64'h1);
    applyStimulus(8'h75, 1'b0);
    applyStimulus(8'h66, 1'b0);
    checkOutput("e075_66_reg1", reg1, (64'h1 << 53) | (64'h1 << 38));
    checkOutput("e075_66_flags", {62'h0, dut.r_breakFlag, dut.r_extFlag}, 64'h0);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h75, 1'b0);
    checkOutput("e0f075_reg1", reg1, 64'h1 << 38);

    // Repeated make keeps the bit set; 0xAA leaves bitmaps alone.
    applyStimulus(8'h66, 1'b0);
    applyStimulus(8'hAA, 1'b0);
    checkOutput("repeat_aa_reg1", reg1, 64'h1 << 38);
    checkOutput("repeat_aa_reg0", reg0, 64'h0);

    // Bad parity after a break prefix: error pulse, flags cleared, nothing else moves.
    applyStimulus(8'hF0, 1'b0);
    v0 = validCount;
    e0 = errCount;
    applyStimulus(8'h1C, 1'b1);
    checkOutput("badpar_err", 64'(errCount - e0), 64'd1);
    checkOutput("badpar_valid", 64'(validCount - v0), 64'd0);
    checkOutput("badpar_code", {56'h0, scanCode}, 64'hF0);
    checkOutput("badpar_flag", {63'h0, dut.r_breakFlag}, 64'h0);
    checkOutput("badpar_reg0", reg0, 64'h0);
    checkOutput("badpar_reg1", reg1, 64'h1 << 38);

    // Timeout after start + 4 data bits.
    v0 = validCount;
    e0 = errCount;
    sendBits(makeFrame(8'h29, 1'b0), 0, 4);
    repeat (TIMEOUT + 100) @(negedge clk);
    checkOutput("timeout_err", 64'(errCount - e0), 64'd1);
    checkOutput("timeout_valid", 64'(validCount - v0), 64'd0);
    checkOutput("timeout_idle", {62'h0, dut.r_state}, 64'h0);
    applyStimulus(8'h29, 1'b0);
    checkOutput("after_to_reg0", reg0, 64'h1 << 41);

    // Reset in the middle of a frame whose remaining bits are all 1.
    frame = makeFrame(8'hF0, 1'b0);
    sendBits(frame, 0, 4);
    v0 = validCount;
    e0 = errCount;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_reg0", reg0, 64'h0);
    checkOutput("midrst_reg1", reg1, 64'h0);
    sendBits(frame, 5, 10);
    repeat (TIMEOUT + 50) @(negedge clk);
    checkOutput("midrst_pulses", 64'((validCount - v0) + (errCount - e0)), 64'd0);
    checkOutput("midrst_idle", {62'h0, dut.r_state}, 64'h0);
    applyStimulus(8'h15, 1'b0);
    checkOutput("after_rst_reg0", reg0, 64'h1 << 21);
    checkOutput("after_rst_code", {56'h0, scanCode}, 64'h15);

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
